// File: rtl/time_frame_tx_seq.sv
// time_frame_tx_seq
//   Streams one watch-time frame "HH:MM:SS\r\n" (10 bytes) into a UART TX FIFO
//   write port. A frame starts on i_start when i_en is high. Pushes are
//   throttled by i_full, so no byte is ever lost. The six digits are
//   snapshotted when the frame starts, so each frame is self-consistent.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-low
//   i_start    one-cycle frame request (normally tick_1s)
//   i_en       enable; gates only the acceptance of new starts
//   i_hour_10 .. i_sec_1   BCD digits (4 bits each)
//   i_full     TX FIFO full
//   o_we       FIFO push strobe (= in SEND and not full)
//   o_wdata    byte being pushed, zero-extended; 0 outside SEND
//   o_busy     frame in progress (SEND or DONE)
//   o_done     one-cycle pulse after the 10th byte is pushed
//   o_drop     one-cycle pulse when a start arrives while busy
//   o_state    debug view of the FSM state (0 IDLE, 1 SEND, 2 DONE)
//
// Handshake: a byte is transferred on every clock edge where o_we is 1.
// o_we is never asserted while i_full is 1. While stalled, o_wdata holds
// the pending byte and the index does not move.
module time_frame_tx_seq #(
  parameter int         DATA_WIDTH = 8,
  parameter logic [7:0] SEP_CHAR   = 8'h3A,
  parameter logic [7:0] ERR_CHAR   = 8'h3F
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_en,
  input  logic [3:0]            i_hour_10,
  input  logic [3:0]            i_hour_1,
  input  logic [3:0]            i_min_10,
  input  logic [3:0]            i_min_1,
  input  logic [3:0]            i_sec_10,
  input  logic [3:0]            i_sec_1,
  input  logic                  i_full,
  output logic                  o_we,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_drop,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] h10_q, h10_d, h1_q, h1_d;
  logic [3:0] m10_q, m10_d, m1_q, m1_d;
  logic [3:0] s10_q, s10_d, s1_q, s1_d;
  logic [7:0] byte_sel;
  logic       push;

  // Out-of-range BCD shows up as ERR_CHAR rather than a misleading glyph.
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    if (d > 4'd9) return ERR_CHAR;
    return 8'h30 + {4'h0, d};
  endfunction

  always_comb begin
    byte_sel = 8'h00;
    case (idx_q)
      4'd0:    byte_sel = digit_char(h10_q);
      4'd1:    byte_sel = digit_char(h1_q);
      4'd2:    byte_sel = SEP_CHAR;
      4'd3:    byte_sel = digit_char(m10_q);
      4'd4:    byte_sel = digit_char(m1_q);
      4'd5:    byte_sel = SEP_CHAR;
      4'd6:    byte_sel = digit_char(s10_q);
      4'd7:    byte_sel = digit_char(s1_q);
      4'd8:    byte_sel = 8'h0D;
      4'd9:    byte_sel = 8'h0A;
      default: byte_sel = 8'h00;
    endcase
  end

  assign push    = (state_q == SEND) && !i_full;
  assign o_we    = push;
  assign o_wdata = (state_q == SEND) ? DATA_WIDTH'(byte_sel) : '0;
  assign o_busy  = (state_q != IDLE);
  assign o_done  = (state_q == DONE);
  // Starts are not queued: one arriving mid-frame is reported and discarded.
  assign o_drop  = i_start && o_busy;
  assign o_state = state_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    h10_d   = h10_q;
    h1_d    = h1_q;
    m10_d   = m10_q;
    m1_d    = m1_q;
    s10_d   = s10_q;
    s1_d    = s1_q;
    case (state_q)
      IDLE: begin
        if (i_start && i_en) begin
          h10_d   = i_hour_10;
          h1_d    = i_hour_1;
          m10_d   = i_min_10;
          m1_d    = i_min_1;
          s10_d   = i_sec_10;
          s1_d    = i_sec_1;
          idx_d   = 4'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (push) begin
          if (idx_q == 4'd9) begin
            idx_d   = 4'd0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      h10_q   <= 4'd0;
      h1_q    <= 4'd0;
      m10_q   <= 4'd0;
      m1_q    <= 4'd0;
      s10_q   <= 4'd0;
      s1_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      h10_q   <= h10_d;
      h1_q    <= h1_d;
      m10_q   <= m10_d;
      m1_q    <= m1_d;
      s10_q   <= s10_d;
      s1_q    <= s1_d;
    end
  end

endmodule

// File: tb/tb_time_frame_tx_seq.sv
module tb_time_frame_tx_seq;

  logic       clk;
  logic       rst;
  logic       i_start;
  logic       i_en;
  logic [3:0] i_hour_10, i_hour_1, i_min_10, i_min_1, i_sec_10, i_sec_1;
  logic       i_full;
  logic       o_we;
  logic [7:0] o_wdata;
  logic       o_busy;
  logic       o_done;
  logic       o_drop;
  logic [1:0] o_state;

  time_frame_tx_seq dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (i_start),
    .i_en      (i_en),
    .i_hour_10 (i_hour_10),
    .i_hour_1  (i_hour_1),
    .i_min_10  (i_min_10),
    .i_min_1   (i_min_1),
    .i_sec_10  (i_sec_10),
    .i_sec_1   (i_sec_1),
    .i_full    (i_full),
    .o_we      (o_we),
    .o_wdata   (o_wdata),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_drop    (o_drop),
    .o_state   (o_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic       prev_last_push = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic logic [7:0] char_of(input logic [3:0] d);
    if (d > 4'd9) return 8'h3F;
    return 8'h30 + {4'h0, d};
  endfunction

  // Expected frame for a digit set, pushed up to n bytes (n<10 for aborted frames).
  task automatic expect_frame(input logic [3:0] d[6], input int n);
    logic [7:0] f[10];
    f[0] = char_of(d[0]); f[1] = char_of(d[1]); f[2] = 8'h3A;
    f[3] = char_of(d[2]); f[4] = char_of(d[3]); f[5] = 8'h3A;
    f[6] = char_of(d[4]); f[7] = char_of(d[5]); f[8] = 8'h0D; f[9] = 8'h0A;
    for (int i = 0; i < n; i++) exp_q.push_back(f[i]);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (o_done) check("done_after_last_push", 32'(prev_last_push), 32'd1);
      if (o_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_push", 32'(o_wdata), 32'hFFFF);
          prev_last_push <= 1'b0;
        end else begin
          check("push_byte", 32'(o_wdata), 32'(exp_q.pop_front()));
          prev_last_push <= (exp_q.size() == 0);
        end
      end else begin
        prev_last_push <= 1'b0;
      end
    end else begin
      // A push presented during the reset edge still lands in the FIFO.
      if (o_we && exp_q.size() != 0) check("push_byte_at_reset", 32'(o_wdata), 32'(exp_q.pop_front()));
      prev_last_push <= 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_digits(input logic [3:0] d[6]);
    i_hour_10 = d[0]; i_hour_1 = d[1];
    i_min_10  = d[2]; i_min_1  = d[3];
    i_sec_10  = d[4]; i_sec_1  = d[5];
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
    tick();
    check({name, "_idle_after"}, 32'(o_busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] dg[6];
  logic [7:0] vec1[10];

  initial begin
    rst = 1'b0; i_start = 1'b0; i_en = 1'b1; i_full = 1'b0;
    dg = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    set_digits(dg);
    tick(); tick(); tick();
    check("reset_we",    32'(o_we),    32'd0);
    check("reset_busy",  32'(o_busy),  32'd0);
    check("reset_done",  32'(o_done),  32'd0);
    check("reset_drop",  32'(o_drop),  32'd0);
    check("reset_wdata", 32'(o_wdata), 32'd0);
    check("reset_state", 32'(o_state), 32'd0);
    rst = 1'b1;
    tick();

    // 1: plain frame 12:34:56, hand-computed bytes
    vec1 = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0D, 8'h0A};
    for (int i = 0; i < 10; i++) exp_q.push_back(vec1[i]);
    dg = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    set_digits(dg);
    pulse_start();
    check("t1_first_we",   32'(o_we),    32'd1);
    check("t1_first_byte", 32'(o_wdata), 32'h31);
    check("t1_busy",       32'(o_busy),  32'd1);
    wait_done("t1_done", 20);

    // 2: stall for 3 cycles while idx 4 is presented
    for (int i = 0; i < 10; i++) exp_q.push_back(vec1[i]);
    pulse_start();
    tick(); tick(); tick(); tick();
    for (int i = 0; i < 3; i++) begin
      i_full = 1'b1;
      #2;
      check("t2_stall_we",    32'(o_we),    32'd0);
      check("t2_stall_wdata", 32'(o_wdata), 32'h34);
      tick();
    end
    i_full = 1'b0;
    wait_done("t2_done", 20);

    // 3: second start 4 cycles into a frame is dropped
    dg = '{4'd2, 4'd3, 4'd5, 4'd9, 4'd0, 4'd1};
    set_digits(dg);
    expect_frame(dg, 10);
    pulse_start();
    tick(); tick(); tick();
    i_start = 1'b1;
    #1;
    check("t3_drop", 32'(o_drop), 32'd1);
    tick();
    i_start = 1'b0;
    #1;
    check("t3_drop_clear", 32'(o_drop), 32'd0);
    wait_done("t3_done", 20);
    tick(); tick(); tick();
    check("t3_single_frame", 32'(exp_q.size()), 32'd0);

    // 4: digits change right after start; snapshot is used
    dg = '{4'd0, 4'd7, 4'd4, 4'd2, 4'd5, 4'd8};
    set_digits(dg);
    expect_frame(dg, 10);
    pulse_start();
    dg = '{4'd9, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9};
    set_digits(dg);
    wait_done("t4_done", 20);

    // 5: invalid BCD -> '?', then disabled start is ignored
    dg = '{4'hC, 4'd1, 4'd0, 4'd0, 4'hF, 4'd3};
    set_digits(dg);
    expect_frame(dg, 10);
    pulse_start();
    check("t5_err_byte", 32'(o_wdata), 32'h3F);
    wait_done("t5_done", 20);
    i_en = 1'b0;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      check("t5_dis_we",   32'(o_we),   32'd0);
      check("t5_dis_busy", 32'(o_busy), 32'd0);
      tick();
    end
    i_en = 1'b1;

    // 6: reset while idx 5 is presented; idx 0..5 land, then a fresh frame
    dg = '{4'd2, 4'd3, 4'd5, 4'd9, 4'd1, 4'd0};
    set_digits(dg);
    expect_frame(dg, 6);
    pulse_start();
    tick(); tick(); tick(); tick(); tick();
    check("t6_idx5_byte", 32'(o_wdata), 32'h3A);
    rst = 1'b0;
    tick();
    check("t6_rst_we",    32'(o_we),    32'd0);
    check("t6_rst_busy",  32'(o_busy),  32'd0);
    check("t6_rst_state", 32'(o_state), 32'd0);
    check("t6_rst_wdata", 32'(o_wdata), 32'd0);
    rst = 1'b1;
    tick();
    dg = '{4'd1, 4'd8, 4'd0, 4'd6, 4'd4, 4'd2};
    set_digits(dg);
    expect_frame(dg, 10);
    pulse_start();
    check("t6_restart_byte", 32'(o_wdata), 32'h31);
    wait_done("t6_done", 20);

    tick(); tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
